// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter.
// Round-robin arbitration per byte, with optional packet locking: a byte
// sent with last=0 keeps the line reserved for its source until that source
// sends a byte with last=1, or until the owner has been idle for LOCK_TO
// consecutive IDLE cycles.
module uart_tx_arbiter #(
  parameter int unsigned BAUD_DIV = 96,   // clk_96mhz cycles per bit, 2..65535
  parameter int unsigned LOCK_TO  = 4096  // idle cycles before lock release, 1..65535
) (
  input  logic       clk_96mhz,
  input  logic       rstn,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       txd,
  output logic       busy,
  output logic       owner,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TO - 1);

  state_t      state_q,    state_d;
  logic [7:0]  shift_q,    shift_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        txd_q,      txd_d;
  logic        busy_q,     busy_d;
  logic        owner_q,    owner_d;
  logic        locked_q,   locked_d;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [7:0]  sel_data;
  logic        sel_last;
  logic        owner_valid;
  logic        baud_tick;

  // Arbitration: decide which (if any) requester is offered ready this cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rstn && (state_q == IDLE)) begin
      if (locked_q) begin
        // Only the lock holder may continue its packet.
        if (owner_q) begin
          grant1 = req1_valid;
        end else begin
          grant0 = req0_valid;
        end
      end else begin
        // The channel that did not send last gets first choice.
        if (owner_q) begin
          if (req0_valid) begin
            grant0 = 1'b1;
          end else begin
            grant1 = req1_valid;
          end
        end else begin
          if (req1_valid) begin
            grant1 = 1'b1;
          end else begin
            grant0 = req0_valid;
          end
        end
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign accept      = grant0 | grant1;
  assign sel_data    = grant1 ? req1_data : req0_data;
  assign sel_last    = grant1 ? req1_last : req0_last;
  assign owner_valid = owner_q ? req1_valid : req0_valid;
  assign baud_tick   = (baud_cnt_q == BAUD_LAST);

  // Next-state logic for the frame sequencer, lock tracking and line driver.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    lock_cnt_d = lock_cnt_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    owner_d    = owner_q;
    locked_d   = locked_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = START;
          shift_d    = sel_data;
          owner_d    = grant1;
          locked_d   = ~sel_last;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          lock_cnt_d = 16'd0;
        end else begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
          if (!locked_q) begin
            lock_cnt_d = 16'd0;
          end else if (!owner_valid) begin
            // Owner has gone quiet while holding the line: time it out.
            if (lock_cnt_q == LOCK_LAST) begin
              locked_d   = 1'b0;
              lock_cnt_d = 16'd0;
            end else begin
              lock_cnt_d = lock_cnt_q + 16'd1;
            end
          end else begin
            lock_cnt_d = lock_cnt_q;
          end
        end
      end

      START: begin
        if (baud_tick) begin
          state_d    = DATA;
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          txd_d      = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (baud_tick) begin
          baud_cnt_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = 3'd0;
            txd_d     = 1'b1;
          end else begin
            // Shift the next LSB into position and drive it.
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (baud_tick) begin
          state_d    = IDLE;
          baud_cnt_d = 16'd0;
          busy_d     = 1'b0;
          txd_d      = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        baud_cnt_d = 16'd0;
        bit_cnt_d  = 3'd0;
        txd_d      = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_96mhz) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      lock_cnt_q <= 16'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      owner_q    <= 1'b1;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      owner_q    <= owner_d;
      locked_q   <= locked_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (BAUD_DIV=4, LOCK_TO=8).
module tb_uart_tx_arbiter;

  localparam int BD = 4;

  logic       clk_96mhz = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_last = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_last = 1'b0;
  logic       req1_ready;
  logic       txd;
  logic       busy;
  logic       owner;
  logic       locked;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  logic       dec_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] acc_q[$];

  uart_tx_arbiter #(.BAUD_DIV(BD), .LOCK_TO(8)) dut (
    .clk_96mhz (clk_96mhz),
    .rstn      (rstn),
    .req0_data (req0_data),
    .req0_valid(req0_valid),
    .req0_last (req0_last),
    .req0_ready(req0_ready),
    .req1_data (req1_data),
    .req1_valid(req1_valid),
    .req1_last (req1_last),
    .req1_ready(req1_ready),
    .txd       (txd),
    .busy      (busy),
    .owner     (owner),
    .locked    (locked)
  );

  always #5 clk_96mhz = ~clk_96mhz;

  always @(posedge clk_96mhz) cyc_cnt++;

  // Serial receiver: samples mid-bit and collects decoded bytes.
  initial begin : decoder
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clk_96mhz);
      if (dec_en && (txd === 1'b0)) begin
        repeat (BD / 2) @(negedge clk_96mhz);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk_96mhz);
          b[i] = txd;
        end
        repeat (BD) @(negedge clk_96mhz);
        rx_q.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_96mhz);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
  endtask

  // Wait (bounded) for a cycle in which a ready is offered; ch=-1 on timeout.
  task automatic wait_accept(output int ch, output int cyc);
    ch  = -1;
    cyc = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_96mhz);
      if (req0_ready && req0_valid) begin
        ch = 0; cyc = cyc_cnt; break;
      end
      if (req1_ready && req1_valid) begin
        ch = 1; cyc = cyc_cnt; break;
      end
    end
  endtask

  initial begin
    int ch, cyc, prev, n, idle;
    logic [9:0] pat;
    int exp_ch[4];
    logic [7:0] exp_rx[4];
    logic exp_lk[4];

    // ---------------- reset state ----------------
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(negedge clk_96mhz);
    check("rst_txd",    32'(txd), 32'd1);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_owner",  32'(owner), 32'd1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_rdy0",   32'(req0_ready), 32'd0);
    check("rst_rdy1",   32'(req1_ready), 32'd0);

    // ---------------- single byte 0xA5 ----------------
    tick();
    rstn = 1'b1;
    req1_valid = 1'b0;
    req0_data = 8'hA5; req0_last = 1'b1; req0_valid = 1'b1;
    @(negedge clk_96mhz);
    check("single_rdy0", 32'(req0_ready), 32'd1);
    check("single_rdy1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    pat = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10 * BD; k++) begin
      @(negedge clk_96mhz);
      check($sformatf("single_txd_%0d", k), 32'(txd), 32'(pat[k / BD]));
      check($sformatf("single_busy_%0d", k), 32'(busy), 32'd1);
    end
    @(negedge clk_96mhz);
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_txd_end",  32'(txd), 32'd1);
    check("single_owner",    32'(owner), 32'd0);
    check("single_locked",   32'(locked), 32'd0);

    // ---------------- round-robin ----------------
    do_reset();
    rx_q.delete();
    dec_en = 1'b1;
    req0_data = 8'h11; req0_last = 1'b1; req0_valid = 1'b1;
    req1_data = 8'h22; req1_last = 1'b1; req1_valid = 1'b1;
    exp_ch = '{0, 1, 0, 1};
    exp_rx = '{8'h11, 8'h22, 8'h11, 8'h22};
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_accept(ch, cyc);
      check($sformatf("rr_ch_%0d", i), 32'(ch), 32'(exp_ch[i]));
      if (i > 0) check($sformatf("rr_gap_%0d", i), 32'(cyc - prev), 32'd41);
      prev = cyc;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (50) @(negedge clk_96mhz);
    dec_en = 1'b0;
    check("rr_rx_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) check($sformatf("rr_rx_%0d", i), 32'(rx_q[i]), 32'(exp_rx[i]));
    end

    // ---------------- packet lock ----------------
    do_reset();
    rx_q.delete();
    dec_en = 1'b1;
    req0_data = 8'h40; req0_last = 1'b0; req0_valid = 1'b1;
    req1_data = 8'h33; req1_last = 1'b1; req1_valid = 1'b1;
    exp_ch = '{0, 0, 0, 1};
    exp_lk = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_rx = '{8'h40, 8'h41, 8'h42, 8'h33};
    for (int i = 0; i < 4; i++) begin
      wait_accept(ch, cyc);
      check($sformatf("lock_ch_%0d", i), 32'(ch), 32'(exp_ch[i]));
      tick();
      if (i == 0) begin req0_data = 8'h41; req0_last = 1'b0; end
      if (i == 1) begin req0_data = 8'h42; req0_last = 1'b1; end
      if (i == 2) req0_valid = 1'b0;
      if (i == 3) req1_valid = 1'b0;
      @(negedge clk_96mhz);
      check($sformatf("lock_locked_%0d", i), 32'(locked), 32'(exp_lk[i]));
      check($sformatf("lock_owner_%0d", i), 32'(owner), 32'(exp_ch[i]));
    end
    repeat (50) @(negedge clk_96mhz);
    dec_en = 1'b0;
    check("lock_rx_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) check($sformatf("lock_rx_%0d", i), 32'(rx_q[i]), 32'(exp_rx[i]));
    end

    // ---------------- lock timeout ----------------
    do_reset();
    req0_data = 8'h55; req0_last = 1'b0; req0_valid = 1'b1;
    req1_data = 8'h66; req1_last = 1'b1; req1_valid = 1'b1;
    wait_accept(ch, cyc);
    check("to_first_ch", 32'(ch), 32'd0);
    tick();
    req0_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk_96mhz);
      n++;
    end while (busy && n < 100);
    check("to_frame_done", 32'(busy), 32'd0);
    check("to_locked_idle", 32'(locked), 32'd1);
    idle = 0;
    while (!req1_ready && idle < 50) begin
      idle++;
      @(negedge clk_96mhz);
    end
    check("to_idle_cycles", 32'(idle), 32'd8);
    check("to_locked_released", 32'(locked), 32'd0);
    check("to_rdy1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk_96mhz);
    check("to_owner1", 32'(owner), 32'd1);
    check("to_busy1", 32'(busy), 32'd1);

    // ---------------- reset mid-frame ----------------
    do_reset();
    req0_data = 8'hF0; req0_last = 1'b0; req0_valid = 1'b1;
    wait_accept(ch, cyc);
    check("mid_ch", 32'(ch), 32'd0);
    tick();
    req0_valid = 1'b0;
    repeat (18) @(negedge clk_96mhz);
    check("mid_txd_bit3", 32'(txd), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_locked", 32'(locked), 32'd1);
    rstn = 1'b0;
    @(negedge clk_96mhz);
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_owner", 32'(owner), 32'd1);
    tick();
    rstn = 1'b1;
    req0_data = 8'h01; req0_last = 1'b1; req0_valid = 1'b1;
    req1_data = 8'h02; req1_last = 1'b1; req1_valid = 1'b1;
    @(negedge clk_96mhz);
    check("mid_after_rdy0", 32'(req0_ready), 32'd1);
    check("mid_after_rdy1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // ---------------- random valid/last, scoreboard ----------------
    do_reset();
    rx_q.delete();
    acc_q.delete();
    dec_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      req0_valid = 1'($urandom_range(0, 1));
      req0_data  = 8'($urandom_range(0, 255));
      req0_last  = ($urandom_range(0, 3) != 0);
      req1_valid = 1'($urandom_range(0, 1));
      req1_data  = 8'($urandom_range(0, 255));
      req1_last  = ($urandom_range(0, 3) != 0);
      @(negedge clk_96mhz);
      check("rand_excl", 32'(req0_ready & req1_ready), 32'd0);
      check("rand_rdy_busy", 32'(busy & (req0_ready | req1_ready)), 32'd0);
      if (req0_ready && req0_valid) acc_q.push_back(req0_data);
      if (req1_ready && req1_valid) acc_q.push_back(req1_data);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk_96mhz);
      n++;
    end while (busy && n < 100);
    repeat (30) @(negedge clk_96mhz);
    dec_en = 1'b0;
    check("rand_rx_count", 32'(rx_q.size()), 32'(acc_q.size()));
    for (int i = 0; i < acc_q.size(); i++) begin
      if (i < rx_q.size()) check($sformatf("rand_rx_%0d", i), 32'(rx_q[i]), 32'(acc_q[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
